// File: rtl/instr_encoder_pkg.sv
// Shared constants and field bundle for the RV64 I/S/B instruction encoder.
// Opcodes match the ones the immediate generator decodes.
package instr_encoder_pkg;

    localparam logic [1:0] FMT_I    = 2'd0;
    localparam logic [1:0] FMT_S    = 2'd1;
    localparam logic [1:0] FMT_B    = 2'd2;
    localparam logic [1:0] FMT_RSVD = 2'd3;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [1:0]  fmt;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] imm;
    } instr_fields_t;

    // True when imm[63:lsb] are all equal, i.e. imm fits a signed (lsb+1)-bit field.
    function automatic logic imm_fits(input logic [63:0] imm, input int unsigned lsb);
        logic [63:0] hi;
        hi = 64'($signed(imm) >>> lsb);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational legality check and bit packing of decoded fields into one
// RV64 instruction word; illegal inputs collapse to the canonical NOP.
module instr_field_pack
    import instr_encoder_pkg::*;
(
    input  instr_fields_t f,
    output logic [31:0]   instr,
    output logic          illegal
);

    logic [31:0] raw;
    logic        ok;

    always_comb begin
        raw = NOP_INSTR;
        ok  = 1'b0;
        case (f.fmt)
            FMT_I: begin
                ok  = (f.opcode == OP_IMM || f.opcode == OP_LOAD) && imm_fits(f.imm, 11);
                raw = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
            end
            FMT_S: begin
                ok  = (f.opcode == OP_STORE) && imm_fits(f.imm, 11);
                raw = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
            end
            FMT_B: begin
                // 13-bit signed range plus even offset gives [-4096, 4094].
                ok  = (f.opcode == OP_BRANCH) && imm_fits(f.imm, 12) && !f.imm[0];
                raw = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                       f.imm[4:1], f.imm[11], f.opcode};
            end
            FMT_RSVD: begin
                ok  = 1'b0;
                raw = NOP_INSTR;
            end
        endcase
    end

    assign illegal = !ok;
    assign instr   = ok ? raw : NOP_INSTR;

endmodule

// File: rtl/instr_encoder.sv
// Stream encoder: one registered output stage, byte-address tagging of each
// emitted word, and a saturating count of illegal inputs.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [63:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [15:0]       err_count
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    instr_fields_t     fields;
    logic [31:0]       pack_instr;
    logic              pack_illegal;
    logic [ADDR_W-1:0] next_addr;
    logic              xfer;

    assign fields = '{fmt: in_fmt, opcode: in_opcode, funct3: in_funct3,
                      rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};

    instr_field_pack u_pack (
        .f       (fields),
        .instr   (pack_instr),
        .illegal (pack_illegal)
    );

    // clear blocks intake so a restart never races an accepted word.
    assign in_ready = !clear && (!out_valid || out_ready);
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= BASE;
            out_err   <= 1'b0;
            err_count <= '0;
            next_addr <= BASE;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_instr <= pack_instr;
                out_err   <= pack_illegal;
                out_addr  <= next_addr;
                next_addr <= next_addr + ADDR_W'(4);
                if (pack_illegal && err_count != 16'hFFFF)
                    err_count <= err_count + 16'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // The pending word keeps its address; only the counters restart.
            if (clear) begin
                next_addr <= BASE;
                err_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench: directed vector table, hand sequences for back-pressure,
// clear, mid-stream reset and saturation, then randomized traffic vs a model.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    localparam int AW = 10, BASE = 0, SAW = 4, SBASE = 8;

    logic clk, rst_n, clear, in_valid, out_ready;
    logic [1:0] in_fmt;
    logic [6:0] in_opcode;
    logic [2:0] in_funct3;
    logic [4:0] in_rd, in_rs1, in_rs2;
    logic [63:0] in_imm;
    logic in_ready, out_valid, out_err;
    logic [31:0] out_instr;
    logic [AW-1:0] out_addr;
    logic [15:0] err_count;
    logic s_in_ready, s_out_valid, s_out_err;
    logic [31:0] s_out_instr;
    logic [SAW-1:0] s_out_addr;
    logic [15:0] s_err_count;

    instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
        .out_err(out_err), .err_count(err_count));

    // Narrow-address twin fed the same stream: exercises wrap to 0 with a non-zero base.
    instr_encoder #(.ADDR_W(SAW), .BASE_ADDR(SBASE)) dut_s (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_instr(s_out_instr), .out_addr(s_out_addr),
        .out_err(s_out_err), .err_count(s_err_count));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        int          addr;
        int          saddr;
        logic        err;
        logic [63:0] imm;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        int          addr;
        logic        err;
    } obs_t;

    typedef struct {
        logic [1:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd, rs1, rs2;
        logic [63:0] imm;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    exp_t q[$];
    obs_t obs[$];
    int   m_next, s_next, m_err;
    int   total = 0, bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit legal_of(input logic [1:0] fmt, input logic [6:0] op, input logic [63:0] imm);
        longint v;
        v = longint'(imm);
        case (fmt)
            2'd0:    return (op == 7'b0010011 || op == 7'b0000011) && v >= -2048 && v <= 2047;
            2'd1:    return op == 7'b0100011 && v >= -2048 && v <= 2047;
            2'd2:    return op == 7'b1100011 && v >= -4096 && v <= 4094 && (v % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] encode(input logic [1:0] fmt, input logic [6:0] op,
                                           input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [63:0] u);
        logic [31:0] r;
        r = 32'(op) | (32'(f3) << 12) | (32'(rs1) << 15);
        case (fmt)
            2'd0: r = r | (32'(rd) << 7) | (32'(u & 64'hFFF) << 20);
            2'd1: r = r | (32'(rs2) << 20) | (32'((u >> 5) & 64'h7F) << 25) | (32'(u & 64'h1F) << 7);
            default: r = r | (32'(rs2) << 20) | (32'((u >> 12) & 64'h1) << 31)
                           | (32'((u >> 5) & 64'h3F) << 25) | (32'((u >> 1) & 64'hF) << 8)
                           | (32'((u >> 11) & 64'h1) << 7);
        endcase
        return r;
    endfunction

    // Immediate generator: recover the sign-extended immediate from a word.
    function automatic logic [63:0] decode_imm(input logic [31:0] w);
        logic [11:0] i12;
        logic [12:0] b13;
        case (w[6:0])
            7'b0100011: begin
                i12 = {w[31:25], w[11:7]};
                return 64'(longint'($signed(i12)));
            end
            7'b1100011: begin
                b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};
                return 64'(longint'($signed(b13)));
            end
            default: begin
                i12 = w[31:20];
                return 64'(longint'($signed(i12)));
            end
        endcase
    endfunction

    // Scoreboard: sample away from the edge, model the next edge's effect.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_next = BASE; s_next = SBASE; m_err = 0;
        end else begin
            automatic bit ev = (q.size() != 0);
            automatic bit er = !clear && (!ev || out_ready);
            chk("in_ready", 64'(in_ready), 64'(er));
            chk("s_in_ready", 64'(s_in_ready), 64'(er));
            chk("out_valid", 64'(out_valid), 64'(ev));
            chk("s_out_valid", 64'(s_out_valid), 64'(ev));
            chk("err_count", 64'(err_count), 64'(m_err));
            chk("s_err_count", 64'(s_err_count), 64'(m_err));
            if (ev) begin
                chk("out_instr", 64'(out_instr), 64'(q[0].instr));
                chk("out_addr", 64'(out_addr), 64'(q[0].addr));
                chk("out_err", 64'(out_err), 64'(q[0].err));
                chk("s_out_instr", 64'(s_out_instr), 64'(q[0].instr));
                chk("s_out_addr", 64'(s_out_addr), 64'(q[0].saddr));
                chk("s_out_err", 64'(s_out_err), 64'(q[0].err));
                if (out_ready) begin
                    automatic exp_t e = q.pop_front();
                    obs.push_back('{instr: out_instr, addr: int'(out_addr), err: out_err});
                    if (!e.err) chk("roundtrip_imm", decode_imm(out_instr), e.imm);
                end
            end
            if (clear) begin
                m_next = BASE; s_next = SBASE; m_err = 0;
            end else if (in_valid && er) begin
                automatic exp_t e;
                automatic bit lg = legal_of(in_fmt, in_opcode, in_imm);
                e.instr = lg ? encode(in_fmt, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm)
                             : 32'h0000_0013;
                e.err = !lg; e.imm = in_imm; e.addr = m_next; e.saddr = s_next;
                q.push_back(e);
                m_next = (m_next + 4) % (1 << AW);
                s_next = (s_next + 4) % (1 << SAW);
                if (!lg && m_err != 65535) m_err++;
            end
        end
    end

    task automatic drive(input logic [1:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [63:0] imm);
        in_fmt = fmt; in_opcode = op; in_funct3 = f3; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    vec_t tbl[14];
    logic [63:0] bnd[9];

    initial begin
        automatic int nerr = 0;
        tbl[0]  = '{2'd0, 7'b0010011, 3'd0, 5'd1, 5'd2, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFF10093, 1'b0};
        tbl[1]  = '{2'd1, 7'b0100011, 3'd3, 5'd0, 5'd2, 5'd5, 64'd8,                  32'h00513423, 1'b0};
        tbl[2]  = '{2'd2, 7'b1100011, 3'd0, 5'd0, 5'd1, 5'd2, -64'sd4,                32'hFE208EE3, 1'b0};
        tbl[3]  = '{2'd0, 7'b0010011, 3'd0, 5'd1, 5'd2, 5'd0, 64'd2048,               32'h00000013, 1'b1};
        tbl[4]  = '{2'd2, 7'b1100011, 3'd0, 5'd0, 5'd1, 5'd2, 64'd3,                  32'h00000013, 1'b1};
        tbl[5]  = '{2'd3, 7'b0010011, 3'd0, 5'd1, 5'd2, 5'd0, 64'd0,                  32'h00000013, 1'b1};
        tbl[6]  = '{2'd0, 7'b0000011, 3'd2, 5'd3, 5'd4, 5'd0, 64'd2047,               32'h7FF22183, 1'b0};
        tbl[7]  = '{2'd1, 7'b0100011, 3'd0, 5'd0, 5'd0, 5'd0, -64'sd2048,             32'h80000023, 1'b0};
        tbl[8]  = '{2'd2, 7'b1100011, 3'd0, 5'd0, 5'd0, 5'd0, 64'd4094,               32'h7E000FE3, 1'b0};
        tbl[9]  = '{2'd2, 7'b1100011, 3'd0, 5'd0, 5'd0, 5'd0, -64'sd4096,             32'h80000063, 1'b0};
        tbl[10] = '{2'd2, 7'b1100011, 3'd0, 5'd0, 5'd0, 5'd0, 64'd4096,               32'h00000013, 1'b1};
        tbl[11] = '{2'd0, 7'b0100011, 3'd0, 5'd1, 5'd2, 5'd0, 64'd5,                  32'h00000013, 1'b1};
        tbl[12] = '{2'd0, 7'b0010011, 3'd0, 5'd1, 5'd2, 5'd0, 64'h0000_0001_0000_0000, 32'h00000013, 1'b1};
        tbl[13] = '{2'd1, 7'b0100011, 3'd0, 5'd0, 5'd0, 5'd0, -64'sd2049,             32'h00000013, 1'b1};
        bnd = '{-64'sd4097, -64'sd4096, -64'sd2049, -64'sd2048, 64'd2047, 64'd2048, 64'd4094, 64'd4095, 64'd4096};

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(2'd0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 64'd0);
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        chk("rst_out_addr", 64'(out_addr), 64'(BASE));
        chk("rst_s_out_addr", 64'(s_out_addr), 64'(SBASE));
        chk("rst_out_err", 64'(out_err), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        step(1);
        rst_n = 1'b1;

        // Directed table, back-to-back at full throughput.
        obs.delete();
        foreach (tbl[i]) begin
            step(1);
            drive(tbl[i].fmt, tbl[i].op, tbl[i].f3, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
            in_valid = 1'b1;
            if (tbl[i].err) nerr++;
        end
        step(1);
        in_valid = 1'b0;
        step(3);
        chk("table_count", 64'(obs.size()), 64'(14));
        foreach (tbl[i]) begin
            if (i < obs.size()) begin
                chk($sformatf("tbl%0d_instr", i), 64'(obs[i].instr), 64'(tbl[i].instr));
                chk($sformatf("tbl%0d_err", i), 64'(obs[i].err), 64'(tbl[i].err));
                chk($sformatf("tbl%0d_addr", i), 64'(obs[i].addr), 64'(BASE + 4 * i));
            end
        end
        chk("table_err_count", 64'(err_count), 64'(nerr));

        // Back-pressure: consumer stalls 3 cycles while input keeps offering.
        out_ready = 1'b0;
        in_valid = 1'b1;
        drive(2'd0, 7'b0010011, 3'd0, 5'd5, 5'd6, 5'd0, 64'd100);
        step(1);
        drive(2'd1, 7'b0100011, 3'd2, 5'd0, 5'd7, 5'd8, -64'sd12);
        step(3);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        step(1);
        drive(2'd2, 7'b1100011, 3'd1, 5'd0, 5'd9, 5'd10, 64'd64);
        step(1);
        in_valid = 1'b0;
        step(3);

        // Clear with a pending word: it keeps its address, next word restarts at base.
        out_ready = 1'b0;
        in_valid = 1'b1;
        drive(2'd3, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 64'd0);
        step(1);
        drive(2'd0, 7'b0010011, 3'd0, 5'd1, 5'd1, 5'd0, 64'd1);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("clear_err_count", 64'(err_count), 64'd0);
        out_ready = 1'b1;
        step(2);
        in_valid = 1'b0;
        step(3);

        // Mid-stream reset with a word pending and input offered.
        in_valid = 1'b1;
        out_ready = 1'b0;
        drive(2'd3, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 64'd0);
        step(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_err_count", 64'(err_count), 64'd0);
        chk("midrst_out_addr", 64'(out_addr), 64'(BASE));
        chk("midrst_out_instr", 64'(out_instr), 64'd0);
        step(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(2'd0, 7'b0000011, 3'd3, 5'd2, 5'd3, 5'd0, -64'sd8);
        step(1);
        in_valid = 1'b0;
        step(1);
        chk("post_rst_addr", 64'(out_addr), 64'(BASE));

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            automatic logic [6:0] op;
            automatic logic [63:0] imm;
            case ($urandom_range(0, 4))
                0: op = OP_IMM;
                1: op = OP_LOAD;
                2: op = OP_STORE;
                3: op = OP_BRANCH;
                default: op = 7'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0: imm = 64'(longint'($urandom_range(0, 10000)) - 64'sd5000);
                1: imm = bnd[$urandom_range(0, 8)];
                2: imm = {$urandom, $urandom};
                default: imm = 64'd1 << $urandom_range(12, 63);
            endcase
            drive(2'($urandom_range(0, 3)), op, 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 49) == 0);
            step(1);
        end
        clear = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step(3);

        // Saturation: stream illegal words past 16'hFFFF.
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        in_valid = 1'b1;
        drive(2'd3, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 64'd0);
        step(65540);
        in_valid = 1'b0;
        step(2);
        chk("saturated_err_count", 64'(err_count), 64'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the immediate generator: packs decoded instruction fields plus a 64-bit sign-extended immediate back into a 32-bit RV64 instruction word (I, S, B formats).
- Used by the instruction-memory loader and the verification harness, so decode(encode(x)) round-trips exactly.
- Valid/ready stream in and out, one registered output stage, and a running byte-address counter that tags each emitted word with its instruction-memory address.

Parameters:
- ADDR_W, 10, width of the instruction-memory byte address (out_addr).
- BASE_ADDR, 0, first address emitted after reset or clear; must be a multiple of 4.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous restart of address counter and error counter.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder can accept fields this cycle.
- in_fmt  in  2  format: 0=I, 1=S, 2=B, 3=reserved.
- in_opcode  in  7  opcode.
- in_funct3  in  3  funct3.
- in_rd  in  5  destination register (I only).
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2 (S, B).
- in_imm  in  64  sign-extended immediate. For shifts the caller supplies the raw 12-bit pattern, including the funct6 bits.
- out_valid  out  1  out_instr/out_addr/out_err valid.
- out_ready  in  1  consumer accepts output.
- out_instr  out  32  encoded instruction word.
- out_addr  out  ADDR_W  byte address assigned to out_instr.
- out_err  out  1  input was illegal; out_instr is NOP.
- err_count  out  16  saturating count of illegal inputs.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_err=0, err_count=0.
  - Internal next-address register = BASE_ADDR.
  - Any in-flight word is discarded.
- Handshake and throughput:
  - in_ready = !clear && (!out_valid || out_ready).
  - A transfer occurs on a rising edge with in_valid && in_ready.
  - Latency 1: fields accepted at edge N appear with out_valid=1 after edge N.
  - Full throughput of 1/cycle while out_ready=1.
- Output hold:
  - out_valid drops at an edge where out_ready=1 and no new transfer occurs.
  - While out_valid && !out_ready, out_instr, out_addr and out_err hold stable.
- Legality, all checked combinationally on the input:
  - I: opcode must be 0010011 or 0000011; imm in [-2048, 2047].
  - S: opcode must be 0100011; imm in [-2048, 2047].
  - B: opcode must be 1100011; imm in [-4096, 4094] and imm[0]=0.
  - fmt=3 is always illegal.
  - Range check uses the full 64 bits: legal only if imm[63:11] is all-equal (I/S) or imm[63:12] is all-equal (B).
- Packing:
  - I = {imm[11:0], rs1, funct3, rd, opcode}.
  - S = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
- Illegal input:
  - out_instr = 32'h00000013 (addi x0,x0,0) and out_err=1.
  - err_count increments, saturating at 16'hFFFF.
  - The address still advances, so program layout is preserved.
- Address counter:
  - Each transfer loads out_addr with the next-address register, then next-address += 4.
  - Modulo 2^ADDR_W: wraps to 0, not to BASE_ADDR.
- clear=1:
  - Next-address := BASE_ADDR and err_count := 0 on that edge; no transfer that cycle.
  - A pending output word stays valid, with its address unchanged, until consumed.
- Simultaneous transfer and saturation: err_count stays 16'hFFFF.
- rst_n asserted mid-stream: everything returns to reset values immediately; no partial word is ever emitted.

Decomposition:
- Shared package holds:
  - Format constants FMT_I/FMT_S/FMT_B/FMT_RSVD.
  - Opcode constants OP_IMM=0010011, OP_LOAD=0000011, OP_STORE=0100011, OP_BRANCH=1100011.
  - NOP_INSTR=32'h00000013.
  - These are the same opcodes the immediate generator decodes.
- One combinational sub-module, instr_field_pack: legality check and bit packing (fields in, instr/illegal out).
- instr_encoder keeps the handshake, output register, address counter and error counter.

Test Plan:
1. I, opcode 0010011, rd=1, rs1=2, f3=0, imm=64'hFFFF_FFFF_FFFF_FFFF -> out_instr=32'hFFF10093, out_addr=0, out_err=0, one cycle after accept.
2. S, opcode 0100011, f3=011, rs1=2, rs2=5, imm=8 -> 32'h00513423 at out_addr=4. Back-to-back B, opcode 1100011, f3=0, rs1=1, rs2=2, imm=-4 -> 32'hFE208EE3 at out_addr=8.
3. I with imm=2048, then B with imm=3, then fmt=3 -> each gives 32'h00000013 with out_err=1; err_count 1,2,3; addresses keep advancing by 4.
4. out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs frozen. Release -> words emitted in order with no loss or duplication; feed each out_instr through the immediate generator and confirm imm matches.
5. ADDR_W=4, 5 legal transfers -> out_addr 0,4,8,12,0. Pulse clear with a word pending -> pending word keeps its address, next word gets BASE_ADDR, err_count=0.
6. Assert rst_n=0 while out_valid=1 and in_valid=1 -> out_valid=0 and err_count=0 immediately. After release, the first word is at BASE_ADDR.
